// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer sitting directly behind the UART receiver.
//   Every in_done strobe captures in_byte. The consumer sees bytes on a
//   first-word-fall-through valid/ready interface. When the buffer is full
//   and no pop happens in the same cycle, the incoming byte is dropped. A
//   sticky flag and a saturating counter record each drop, so the receiver
//   is never stalled and any loss stays visible.
//
// Ports
//   clk          in   1         system clock, posedge
//   rst          in   1         asynchronous reset, active-high
//   in_byte      in   8         received byte, qualified by in_done
//   in_done      in   1         byte-complete strobe, one push per high cycle
//   out_data     out  8         head byte, don't-care while !out_valid
//   out_valid    out  1         FIFO non-empty
//   out_ready    in   1         consumer takes the head when out_valid
//   count        out  ADDR_W+1  occupancy, 0..DEPTH
//   full         out  1         count == DEPTH
//   overflow     out  1         sticky, set by any dropped byte
//   drop_cnt     out  DROP_W    dropped bytes since last clear, saturating
//   clr_overflow in   1         clears overflow and drop_cnt
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_done,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;
    logic              drop;

    // Status comes only from the registered count, so in_done never
    // reaches an output combinationally.
    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    // A full FIFO can still take a byte in the same cycle its head leaves.
    assign push = in_done & (~full | pop);
    assign drop = in_done & full & ~pop;

    // Storage is left unreset; out_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end

            // A drop in the same cycle as a clear still counts, so the
            // clear acts first and the counter restarts at one.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_overflow) begin
                    drop_cnt <= DROP_ONE;
                end else if (drop_cnt != DROP_MAX) begin
                    drop_cnt <= drop_cnt + DROP_ONE;
                end
            end else if (clr_overflow) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_byte;
    logic       in_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q [$];

    uart_rx_fifo #(.DEPTH(16), .DROP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_byte      (in_byte),
        .in_done      (in_done),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_byte = 8'h00;
        in_done = 1'b0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        #12;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        in_byte = 8'hA5;
        in_done = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", out_valid); end
        tick();
        in_done = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", out_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b exp 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            in_byte = 8'(i);
            in_done = 1'b1;
            tick();
        end
        in_done = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL fill_head got %h exp 00", out_data); end
    endtask

    task automatic test_overflow();
        in_byte = 8'hEE;
        in_done = 1'b1;
        repeat (3) tick();
        in_done = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 3", drop_cnt); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL ovf_head got %h exp 00", out_data); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_flag got %b exp 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop_cnt got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_drain_order();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL drain_empty got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b;
        for (int i = 0; i < 16; i++) begin
            in_byte = 8'h10 + 8'(i);
            in_done = 1'b1;
            tick();
        end
        in_byte = 8'h77;
        in_done = 1'b1;
        out_ready = 1'b1;
        tick();
        in_done = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL pp_count got %0d exp 16", count); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL pp_no_drop got ovf=%b cnt=%0d exp 0 0", overflow, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'h77;
            checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin
                errors++; $display("FAIL pp_drain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_b);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_wrap_stream();
        int  sent;
        int  cyc;
        logic do_push;
        logic do_pop;
        q.delete();
        sent = 0;
        cyc = 0;
        while ((sent < 40 || q.size() != 0) && cyc < 200) begin
            in_done   = (sent < 40);
            in_byte   = 8'h40 + 8'(sent);
            out_ready = (cyc % 3 != 0);
            #1;
            checks++; if (out_valid !== (q.size() != 0) || count !== 5'(q.size())) begin
                errors++; $display("FAIL wrap_state_%0d got v=%b c=%0d exp v=%b c=%0d", cyc, out_valid, count, q.size() != 0, q.size());
            end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin
                    errors++; $display("FAIL wrap_data_%0d got %h exp %h", cyc, out_data, q[0]);
                end
            end
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_done && (q.size() < 16 || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(in_byte);
                sent++;
            end
            tick();
            cyc++;
        end
        in_done = 1'b0;
        out_ready = 1'b0;
        checks++; if (sent != 40 || q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_complete got sent=%0d left=%0d v=%b exp 40 0 0", sent, q.size(), out_valid);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) begin
            in_byte = 8'(i + 8'hB0);
            in_done = 1'b1;
            tick();
        end
        in_byte = 8'hDD;
        repeat (255) tick();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", drop_cnt); end
        repeat (45) tick();
        in_done = 1'b0;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", overflow); end
        checks++; if (out_data !== 8'hB0 || count !== 5'd16) begin
            errors++; $display("FAIL sat_contents got d=%h c=%0d exp b0 16", out_data, count);
        end
        in_done = 1'b1;
        clr_overflow = 1'b1;
        tick();
        in_done = 1'b0;
        clr_overflow = 1'b0;
        checks++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
            errors++; $display("FAIL clr_vs_drop got cnt=%0d ovf=%b exp 1 1", drop_cnt, overflow);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        repeat (11) tick();
        out_ready = 1'b0;
        checks++; if (count !== 5'd5 || overflow !== 1'b1) begin
            errors++; $display("FAIL mid_pre got c=%0d ovf=%b exp 5 1", count, overflow);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_async got c=%0d v=%b exp 0 0", count, out_valid);
        end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_async_ovf got ovf=%b cnt=%0d exp 0 0", overflow, drop_cnt);
        end
        tick();
        rst = 1'b0;
        in_byte = 8'hC3;
        in_done = 1'b1;
        tick();
        in_byte = 8'h3C;
        tick();
        in_done = 1'b0;
        checks++; if (out_data !== 8'hC3 || count !== 5'd2) begin
            errors++; $display("FAIL mid_first got d=%h c=%0d exp c3 2", out_data, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_data !== 8'h3C || count !== 5'd1) begin
            errors++; $display("FAIL mid_second got d=%h c=%0d exp 3c 1", out_data, count);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_overflow();
        test_drain_order();
        test_full_push_pop();
        test_wrap_stream();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
